mem_bus_ctrl: RTL

Memory/IO bus controller that sits directly downstream of the CPU control FSM and datapath. It executes the `mem_cmd` / `mem_addr` / `write_data` transactions the FSM issues during instruction fetch, LDR and STR. Each transaction is decoded to one of three targets: the 256-word data/instruction RAM, the memory-mapped LED register, or the memory-mapped switch port. It returns registered `read_data` (the FSM's `mdata` / instruction source) and flags illegal accesses with a sticky error.

---
 rtl/mem_bus_ctrl_if.sv | 14 +
 rtl/mem_bus_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory bus: command, address and store data in, registered read data out.
// No handshake: a command presented in a cycle always completes at that cycle's closing edge.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (output mem_cmd, output mem_addr, output write_data, input read_data);
  modport slave  (input mem_cmd, input mem_addr, input write_data, output read_data);
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-cycle bus controller decoding CPU transactions to RAM, LED register and switch port,
// with registered read data and a sticky first-error address capture.
module mem_bus_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_ctrl_if.slave     bus,
  input  logic [9:0]        sw,
  output logic [7:0]        led,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr
);
  localparam int IDX_W = $clog2(RAM_WORDS);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_hit, led_hit, sw_hit;
  logic              is_read, ram_we, led_we, err_now;
  logic [9:0]        sw_meta, sw_sync;

  assign ram_idx = bus.mem_addr[IDX_W-1:0];

  always_comb begin
    ram_hit = ~bus.mem_addr[ADDR_W-1];
    led_hit = (bus.mem_addr == LED_ADDR);
    sw_hit  = (bus.mem_addr == SW_ADDR);
    is_read = 1'b0;
    ram_we  = 1'b0;
    led_we  = 1'b0;
    err_now = 1'b0;
    case (bus.mem_cmd)
      MNONE: ;
      MREAD: begin
        is_read = 1'b1;
        err_now = ~(ram_hit | led_hit | sw_hit);
      end
      MWRITE: begin
        ram_we  = ram_hit;
        led_we  = led_hit;
        err_now = ~(ram_hit | led_hit);
      end
      default: err_now = 1'b1;
    endcase
  end

  // RAM has no reset; a write presented while reset is low is simply dropped.
  always_ff @(posedge clk) begin
    if (reset && ram_we)
      ram[ram_idx] <= bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.read_data <= '0;
      led           <= '0;
      bus_err       <= 1'b0;
      err_addr      <= '0;
      sw_meta       <= '0;
      sw_sync       <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (is_read) begin
        if (ram_hit)      bus.read_data <= ram[ram_idx];
        else if (led_hit) bus.read_data <= {{(DATA_W-8){1'b0}}, led};
        else if (sw_hit)  bus.read_data <= {{(DATA_W-10){1'b0}}, sw_sync};
        else              bus.read_data <= '0;
      end
      if (led_we)
        led <= bus.write_data[7:0];
      // Only the first illegal access since reset is recorded.
      if (err_now) begin
        bus_err <= 1'b1;
        if (!bus_err)
          err_addr <= bus.mem_addr;
      end
    end
  end
endmodule
